// File: rtl/modmul_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : modmul_arbiter_if
//  Description : Bundle of the two requester ports, the shared modular
//                multiplier port and the two response ports of
//                modmul_arbiter. The arbiter connects through the slave
//                modport; the environment (requesters plus the multiplier)
//                uses the master modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface modmul_arbiter_if #(
  parameter int W = 14
);
  // requester side
  logic         req0_vld;
  logic         req1_vld;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req0_rdy;
  logic         req1_rdy;

  // shared multiplier side
  logic         mm_vld;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_p;

  // response side
  logic         rsp0_vld;
  logic         rsp1_vld;
  logic [W-1:0] rsp0_p;
  logic [W-1:0] rsp1_p;
  logic         err0;
  logic         err1;

  modport slave (
    input  req0_vld, req1_vld, req0_a, req0_b, req1_a, req1_b, mm_p,
    output req0_rdy, req1_rdy, mm_vld, mm_a, mm_b,
           rsp0_vld, rsp1_vld, rsp0_p, rsp1_p, err0, err1
  );

  modport master (
    output req0_vld, req1_vld, req0_a, req0_b, req1_a, req1_b, mm_p,
    input  req0_rdy, req1_rdy, mm_vld, mm_a, mm_b,
           rsp0_vld, rsp1_vld, rsp0_p, rsp1_p, err0, err1
  );
endinterface
`default_nettype wire

// File: rtl/modmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : modmul_arbiter
//  Description : Two-requester round-robin front end for a shared, fixed-
//                latency modular multiplier. One request is accepted and
//                issued per cycle; a LAT+1 stage tag pipeline carries the
//                requester id back so each result is routed to its owner,
//                in acceptance order, LAT+2 cycles after acceptance.
//  Options     : define MODMUL_ARB_RANGE_CHECK_EN to reject operands >= Q
//                (not issued, answered with rsp_p=0 and err=1).
//  Revision    : 1.0  initial release
// ============================================================================
module modmul_arbiter #(
  parameter int           W   = 14,
  parameter logic [W-1:0] Q   = 14'd12289,
  parameter int           LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  modmul_arbiter_if.slave bus
);

  // An illegal configuration never grants, so it can never issue garbage.
  localparam bit c_cfg_ok = (LAT >= 1) && (LAT <= 8) && (Q > W'(1));

  // arbitration
  logic         gnt0;
  logic         gnt1;
  logic         acc;
  logic         acc_id;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic         bad;
  logic         issue;
  logic         ptr_q;
  logic         ptr_d;

  // multiplier issue registers
  logic         mm_vld_q;
  logic         mm_vld_d;
  logic [W-1:0] mm_a_q;
  logic [W-1:0] mm_a_d;
  logic [W-1:0] mm_b_q;
  logic [W-1:0] mm_b_d;

  // tag pipeline: stage 0 lines up with mm_vld, stage LAT with mm_p
  logic [LAT:0] tag_vld_q;
  logic [LAT:0] tag_vld_d;
  logic [LAT:0] tag_id_q;
  logic [LAT:0] tag_id_d;
  logic [LAT:0] tag_err_q;
  logic [LAT:0] tag_err_d;

  // response registers
  logic [W-1:0] rsp_val;
  logic         rsp0_vld_q;
  logic         rsp0_vld_d;
  logic         rsp1_vld_q;
  logic         rsp1_vld_d;
  logic [W-1:0] rsp0_p_q;
  logic [W-1:0] rsp0_p_d;
  logic [W-1:0] rsp1_p_q;
  logic [W-1:0] rsp1_p_d;
  logic         err0_q;
  logic         err0_d;
  logic         err1_q;
  logic         err1_d;

  // Grant: a lone requester always wins, under contention the pointer decides.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && c_cfg_ok) begin
      gnt0 = bus.req0_vld && (!ptr_q || !bus.req1_vld);
      gnt1 = bus.req1_vld && ( ptr_q || !bus.req0_vld);
    end
    acc    = gnt0 || gnt1;
    acc_id = gnt1;
    sel_a  = gnt1 ? bus.req1_a : bus.req0_a;
    sel_b  = gnt1 ? bus.req1_b : bus.req0_b;
  end

`ifdef MODMUL_ARB_RANGE_CHECK_EN
  // Flag accepted operands that are not reduced modulo Q.
  always_comb begin
    bad = (sel_a >= Q) || (sel_b >= Q);
  end
`else
  // Range checking not built: every accepted request is issued as-is.
  always_comb begin
    bad = 1'b0;
  end
`endif

  // Pointer moves to the loser after each acceptance; operands hold when idle.
  always_comb begin
    issue    = acc && !bad;
    ptr_d    = acc ? !acc_id : ptr_q;
    mm_vld_d = issue;
    mm_a_d   = issue ? sel_a : mm_a_q;
    mm_b_d   = issue ? sel_b : mm_b_q;
  end

  // Every acceptance (issued or rejected) enters the tag pipeline.
  always_comb begin
    tag_vld_d = {tag_vld_q[LAT-1:0], acc};
    tag_id_d  = {tag_id_q[LAT-1:0],  acc_id};
    tag_err_d = {tag_err_q[LAT-1:0], acc && bad};
  end

  // Route the result at the pipeline tail to its owner; rejected ones read 0.
  always_comb begin
    rsp_val    = tag_err_q[LAT] ? '0 : bus.mm_p;
    rsp0_vld_d = tag_vld_q[LAT] && !tag_id_q[LAT];
    rsp1_vld_d = tag_vld_q[LAT] &&  tag_id_q[LAT];
    rsp0_p_d   = rsp0_vld_d ? rsp_val : rsp0_p_q;
    rsp1_p_d   = rsp1_vld_d ? rsp_val : rsp1_p_q;
    err0_d     = rsp0_vld_d && tag_err_q[LAT];
    err1_d     = rsp1_vld_d && tag_err_q[LAT];
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      mm_vld_q   <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      tag_err_q  <= '0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
      rsp0_p_q   <= '0;
      rsp1_p_q   <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      mm_vld_q   <= mm_vld_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      tag_err_q  <= tag_err_d;
      rsp0_vld_q <= rsp0_vld_d;
      rsp1_vld_q <= rsp1_vld_d;
      rsp0_p_q   <= rsp0_p_d;
      rsp1_p_q   <= rsp1_p_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  assign bus.req0_rdy = gnt0;
  assign bus.req1_rdy = gnt1;
  assign bus.mm_vld   = mm_vld_q;
  assign bus.mm_a     = mm_a_q;
  assign bus.mm_b     = mm_b_q;
  assign bus.rsp0_vld = rsp0_vld_q;
  assign bus.rsp1_vld = rsp1_vld_q;
  assign bus.rsp0_p   = rsp0_p_q;
  assign bus.rsp1_p   = rsp1_p_q;
  assign bus.err0     = err0_q;
  assign bus.err1     = err1_q;

endmodule
`default_nettype wire
